// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;
endpackage

// File: rtl/if_id_reg.sv
// Fetch-to-decode output register: loads a fetched word, holds it while decode
// stalls, clears it once accepted, and drops it on a flush.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Output word register; flush wins over load so a redirect never leaks a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= {XLEN{1'b0}};
      pc    <= {XLEN{1'b0}};
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC sequencing, RUN/HALT control, redirect handling
// and a saturating count of words accepted by decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] LAST_PC  = 32'd356,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic              fetch;
  logic              accept;
  logic [CNT_W-1:0]  count_next;

  // State, PC and accepted-word counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_count <= {CNT_W{1'b0}};
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_count <= count_next;
    end
  end

  // Next-state, next-PC and fetch decision; a redirect overrides everything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fetch      = 1'b0;
    if (redirect_valid) begin
      pc_next    = {redirect_target[XLEN-1:2], 2'b00};
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!id_valid || id_ready) begin
            fetch   = 1'b1;
            pc_next = pc + PC_STEP;
            if (pc == LAST_PC) begin
              state_next = HALT;
            end else begin
              state_next = RUN;
            end
          end else begin
            state_next = RUN;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Counter saturates at all-ones; a flushed word is not counted as accepted.
  always_comb begin
    accept = id_valid && id_ready && !redirect_valid;
    if (accept && (fetch_count != {CNT_W{1'b1}})) begin
      count_next = fetch_count + CNT_W'(1);
    end else begin
      count_next = fetch_count;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (fetch),
    .flush    (redirect_valid),
    .ready    (id_ready),
    .instr_in (imem_data),
    .pc_in    (pc),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (default and wrap-around/narrow
// counter) checked every cycle against a behavioural model plus directed pins.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        ready;
  logic        redir0, redir1;
  logic [31:0] target0, target1;

  logic [31:0] addr0, addr1, data0, data1;
  logic        valid0, valid1, halted0, halted1;
  logic [31:0] instr0, instr1, idpc0, idpc1;
  logic [15:0] fc0;
  logic [2:0]  fc1;

  int errors = 0;
  int checks = 0;
  bit model_ok = 1'b0;

  typedef struct {
    logic [31:0] pc;
    bit          halt;
    bit          valid;
    logic [31:0] instr;
    logic [31:0] idpc;
    int unsigned cnt;
  } mdl_t;

  mdl_t        m [2];
  int unsigned cmax [2] = '{32'd65535, 32'd7};
  logic [31:0] rpc  [2] = '{32'd0, 32'hFFFF_FFFC};
  logic [31:0] lpc  [2] = '{32'd356, 32'h0000_0004};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign data0 = mem_word(addr0);
  assign data1 = mem_word(addr1);

  instruction_fetch dut0 (
    .clk(clk), .reset(reset), .imem_addr(addr0), .imem_data(data0),
    .redirect_valid(redir0), .redirect_target(target0), .id_ready(ready),
    .id_valid(valid0), .id_instr(instr0), .id_pc(idpc0), .halted(halted0),
    .fetch_count(fc0)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .LAST_PC(32'h0000_0004), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .imem_addr(addr1), .imem_data(data1),
    .redirect_valid(redir1), .redirect_target(target1), .id_ready(ready),
    .id_valid(valid1), .id_instr(instr1), .id_pc(idpc1), .halted(halted1),
    .fetch_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: each program word leaves fetch once, in address order.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit          rv;
      logic [31:0] rt;
      rv = (i == 0) ? redir0 : redir1;
      rt = (i == 0) ? target0 : target1;
      if (reset) begin
        m[i].pc = rpc[i]; m[i].halt = 1'b0; m[i].valid = 1'b0;
        m[i].instr = 32'd0; m[i].idpc = 32'd0; m[i].cnt = 0;
      end else begin
        if (m[i].valid && ready && !rv && m[i].cnt < cmax[i]) m[i].cnt++;
        if (rv) begin
          m[i].pc = rt & ~32'd3;
          m[i].valid = 1'b0;
          m[i].halt = 1'b0;
        end else if (!m[i].halt && (!m[i].valid || ready)) begin
          m[i].instr = mem_word(m[i].pc);
          m[i].idpc = m[i].pc;
          m[i].valid = 1'b1;
          if (m[i].pc == lpc[i]) m[i].halt = 1'b1;
          m[i].pc = m[i].pc + 32'd4;
        end else if (m[i].valid && ready) begin
          m[i].valid = 1'b0;
        end
      end
    end
    if (reset) model_ok = 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("addr0",   addr0,          m[0].pc);
      check("valid0",  32'(valid0),    32'(m[0].valid));
      check("instr0",  instr0,         m[0].instr);
      check("idpc0",   idpc0,          m[0].idpc);
      check("halted0", 32'(halted0),   32'(m[0].halt));
      check("count0",  32'(fc0),       32'(m[0].cnt));
      check("addr1",   addr1,          m[1].pc);
      check("valid1",  32'(valid1),    32'(m[1].valid));
      check("instr1",  instr1,         m[1].instr);
      check("idpc1",   idpc1,          m[1].idpc);
      check("halted1", 32'(halted1),   32'(m[1].halt));
      check("count1",  32'(fc1),       32'(m[1].cnt));
    end
  end

  initial begin
    int k;
    reset = 1'b1; ready = 1'b1;
    redir0 = 1'b0; redir1 = 1'b0; target0 = 32'd0; target1 = 32'd0;
    tick(); tick();
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_addr1", addr1, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Straight-line run to halt, plus wrap-around on the second instance.
    tick();
    check("first_pc0", idpc0, 32'd0);
    check("first_instr0", instr0, mem_word(32'd0));
    check("first_addr0", addr0, 32'd4);
    check("wrap_pc_a", idpc1, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_b", idpc1, 32'd0);
    tick();
    check("wrap_pc_c", idpc1, 32'd4);
    check("wrap_halt", 32'(halted1), 32'd1);
    check("wrap_addr", addr1, 32'd8);
    k = 3;
    while (!halted0 && k < 200) begin tick(); k++; end
    check("halt_cycles", k, 32'd90);
    check("halt_pc", idpc0, 32'd356);
    check("halt_count", 32'(fc0), 32'd89);
    tick();
    check("final_count", 32'(fc0), 32'd90);
    check("model_count", 32'(m[0].cnt), 32'd90);
    check("final_valid", 32'(valid0), 32'd0);
    check("final_addr", addr0, 32'd360);
    check("sat_count1", 32'(fc1), 32'd3);

    // Decode stall while id_pc is 8.
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick();
    check("stall_pre", idpc0, 32'd8);
    ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_pc", idpc0, 32'd8);
      check("stall_addr", addr0, 32'd12);
    end
    ready = 1'b1;
    tick();
    check("resume_pc", idpc0, 32'd12);

    // Redirect flushes a stalled word and aligns the target.
    ready = 1'b0; redir0 = 1'b1; target0 = 32'h0000_0079;
    tick();
    check("flush_valid", 32'(valid0), 32'd0);
    check("redir_addr", addr0, 32'h78);
    redir0 = 1'b0;
    tick();
    check("redir_pc", idpc0, 32'h78);

    // Redirect out of HALT, then halt again at the last word.
    ready = 1'b1; k = 0;
    while (!halted0 && k < 200) begin tick(); k++; end
    check("halt2", 32'(halted0), 32'd1);
    redir0 = 1'b1; target0 = 32'h84;
    tick();
    check("unhalt", 32'(halted0), 32'd0);
    check("unhalt_addr", addr0, 32'h84);
    redir0 = 1'b0;
    tick();
    check("unhalt_pc", idpc0, 32'h84);
    k = 1;
    while (!halted0 && k < 200) begin tick(); k++; end
    check("halt3_cycles", k, 32'd57);
    check("halt3_pc", idpc0, 32'd356);

    // Pending word held in HALT, then discarded by reset.
    ready = 1'b0;
    tick();
    check("halt_hold", 32'(valid0), 32'd1);
    check("halt_hold_addr", addr0, 32'd360);
    reset = 1'b1;
    tick();
    check("rst_drop", 32'(valid0), 32'd0);
    check("rst_count", 32'(fc0), 32'd0);
    check("rst_addr", addr0, 32'd0);
    check("rst_halted", 32'(halted0), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_refetch", idpc0, 32'd0);
    check("rst_refetch_v", 32'(valid0), 32'd1);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      ready   = ($urandom_range(0, 9) < 7);
      redir0  = ($urandom_range(0, 19) == 0);
      target0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(300, 400));
      redir1  = ($urandom_range(0, 7) == 0);
      target1 = 32'hFFFF_FFF0 + 32'($urandom_range(0, 27));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: byte address of the first fetch after reset.
REQ-002 SHALL have parameter LAST_PC, default 32'd356: byte address of the final program word; fetching it halts the unit.
REQ-003 SHALL have parameter CNT_W, default 16: width of fetch_count.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port imem_addr, output, 32: byte address to the combinational instruction memory; always equals the PC register.
REQ-007 SHALL have port imem_data, input, 32: instruction word returned combinationally for imem_addr.
REQ-008 SHALL have port redirect_valid, input, 1: branch/jump taken this cycle.
REQ-009 SHALL have port redirect_target, input, 32: new fetch byte address.
REQ-010 SHALL have port id_ready, input, 1: decode stage can accept a word this cycle.
REQ-011 SHALL have port id_valid, output, 1: id_instr/id_pc hold a valid fetched word.
REQ-012 SHALL have port id_instr, output, 32: fetched instruction.
REQ-013 SHALL have port id_pc, output, 32: byte address of id_instr.
REQ-014 SHALL have port halted, output, 1: unit is in HALT state.
REQ-015 SHALL have port fetch_count, output, CNT_W: instructions accepted by decode since reset.

Function
REQ-016 SHALL implement two states, RUN and HALT; RUN after reset.
REQ-017 SHALL perform a fetch in a cycle when state is RUN, redirect_valid is 0, and (id_valid is 0 or id_ready is 1).
REQ-018 On a fetch, SHALL register id_instr<=imem_data, id_pc<=PC, id_valid<=1, PC<=PC+4 (modulo 2^32, wraps silently); latency address-to-id_valid is one cycle.
REQ-019 When id_valid and id_ready are both 1 and no fetch occurs, SHALL clear id_valid next cycle.
REQ-020 When id_valid is 1 and id_ready is 0, SHALL hold id_instr, id_pc, id_valid and PC unchanged (no word dropped or duplicated).
REQ-021 On a fetch with PC equal to LAST_PC, SHALL transition RUN->HALT; in HALT no fetch occurs, PC stays at LAST_PC+4, the pending output word stays until accepted.
REQ-022 redirect_valid SHALL have highest priority: PC<={redirect_target[31:2],2'b00}, id_valid<=0 (flush, even if id_ready is 0), state<=RUN (also from HALT), no fetch that cycle.
REQ-023 fetch_count SHALL increment by 1 on each cycle with id_valid and id_ready both 1 and redirect_valid 0, saturating at all-ones.
REQ-024 halted SHALL equal (state == HALT) combinationally.

Reset
REQ-025 While reset is 1 at a clock edge: PC<=RESET_PC, state<=RUN, id_valid<=0, id_instr<=0, id_pc<=0, fetch_count<=0; reset overrides redirect and handshake.
REQ-026 Reset asserted mid-stall or mid-halt SHALL discard the pending word; first fetch occurs the first cycle after reset deasserts.

Structure
REQ-027 Shared package fetch_pkg SHALL hold the state enum (RUN, HALT), INSTR_BYTES=4 and XLEN=32.
REQ-028 The output register (id_valid/id_instr/id_pc with hold/flush) SHALL be a sub-module if_id_reg; PC, FSM and counter live in the top.

Verification
REQ-029 Reset then id_ready=1 constant -> imem_addr 0,4,8,...; id_pc 0 appears cycle 1 with id_instr = word at 0; halted=1 the cycle after id_pc=356 is fetched; fetch_count=90 after the final word is accepted.
REQ-030 id_ready=0 for 3 cycles while id_pc=8 -> id_instr/id_pc held, imem_addr stays 12; resuming gives id_pc 12 next, no gap or repeat.
REQ-031 redirect_valid=1, target=0x0000_0079 while id_valid=1, id_ready=0 -> next cycle id_valid=0, imem_addr=0x78; following cycle id_pc=0x78.
REQ-032 From HALT, redirect to 0x84 -> halted=0 next cycle, fetching resumes at 0x84 and halts again after 356.
REQ-033 RESET_PC=32'hFFFF_FFFC, LAST_PC=32'h4 -> fetches 0xFFFF_FFFC, 0x0, 0x4 then halt (wrap check).
REQ-034 reset pulsed while id_valid=1 and id_ready=0 -> id_valid=0, fetch_count=0, imem_addr=RESET_PC next cycle.
